// File: rtl/fully_associative_register_bank.sv
// ============================================================================
// Module   : fully_associative_register_bank
// Brief    : NUM_REGS config registers on one si_* bus; one-shot ack,
//            change pulses and optional shadow/commit double buffering.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef __REG_ADDR_WIDTH
`define __REG_ADDR_WIDTH 8
`endif
`ifndef __REG_DATA_WIDTH
`define __REG_DATA_WIDTH 32
`endif

module fully_associative_register_bank #(
  parameter int REG_ADDR_WIDTH = `__REG_ADDR_WIDTH,
  parameter int REG_DATA_WIDTH = `__REG_DATA_WIDTH,
  parameter int NUM_REGS       = 4,
  parameter logic [REG_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter logic [NUM_REGS*REG_DATA_WIDTH-1:0] RESET_VALUES = '0,
  parameter bit SHADOW_MODE    = 1'b0,
  parameter logic [REG_ADDR_WIDTH-1:0] COMMIT_ADDR = {REG_ADDR_WIDTH{1'b1}}
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [REG_ADDR_WIDTH-1:0]          si_addr,
  input  logic [REG_DATA_WIDTH-1:0]          si_data,
  input  logic                               si_rdy,
  output logic                               si_ack,
  output logic [NUM_REGS*REG_DATA_WIDTH-1:0] data,
  output logic [NUM_REGS-1:0]                data_upd,
  output logic                               shadow_dirty
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [REG_DATA_WIDTH-1:0] r_active [NUM_REGS];
  logic [REG_DATA_WIDTH-1:0] r_shadow [NUM_REGS];
  logic [NUM_REGS-1:0]       r_upd;
  logic                      r_dirty;
  logic [NUM_REGS-1:0]       w_sel;
  logic                      w_commit;
  logic                      w_hit;
  logic                      w_capture;

  if (SHADOW_MODE && (int'(COMMIT_ADDR) >= int'(BASE_ADDR)) &&
      (int'(COMMIT_ADDR) <= int'(BASE_ADDR) + NUM_REGS - 1)) begin : g_commit_addr_check
    $error("COMMIT_ADDR overlaps the register address window");
  end

  // One equality compare per register keeps the decode free of subtraction.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_decode
    localparam logic [REG_ADDR_WIDTH-1:0] c_reg_addr = REG_ADDR_WIDTH'(int'(BASE_ADDR) + gi);
    assign w_sel[gi] = (si_addr == c_reg_addr);
    assign data[gi*REG_DATA_WIDTH +: REG_DATA_WIDTH] = r_active[gi];
  end

  assign w_commit     = SHADOW_MODE && (si_addr == COMMIT_ADDR);
  assign w_hit        = (|w_sel) || w_commit;
  assign w_capture    = (r_state == S_IDLE) && si_rdy && w_hit;
  assign si_ack       = (r_state == S_ACK);
  assign data_upd     = r_upd;
  assign shadow_dirty = SHADOW_MODE ? r_dirty : 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_capture) w_next = S_ACK;
      S_ACK:   w_next = si_rdy ? S_HOLD : S_IDLE;
      S_HOLD:  if (!si_rdy) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_active[i] <= RESET_VALUES[i*REG_DATA_WIDTH +: REG_DATA_WIDTH];
        r_shadow[i] <= RESET_VALUES[i*REG_DATA_WIDTH +: REG_DATA_WIDTH];
      end
      r_upd   <= '0;
      r_dirty <= 1'b0;
    end else begin
      r_upd <= '0;
      if (w_capture) begin
        if (w_commit) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            r_upd[i]    <= (r_shadow[i] != r_active[i]);
            r_active[i] <= r_shadow[i];
          end
          r_dirty <= 1'b0;
        end else if (SHADOW_MODE) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (w_sel[i]) r_shadow[i] <= si_data;
          end
          r_dirty <= 1'b1;
        end else begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (w_sel[i]) begin
              r_upd[i]    <= (si_data != r_active[i]);
              r_active[i] <= si_data;
            end
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/fully_associative_register_bank.md
Name: fully_associative_register_bank

Overview:
- Parametrised bank of NUM_REGS configuration registers sharing one simple-interface (si_*) address/data bus.
- Each register answers at BASE_ADDR+i, with per-register reset values.
- Replaces per-register instances on the configuration bus; adds a registered, one-shot acknowledge, change-notification pulses and optional shadow/commit (double-buffered) updates.

Parameters:
- REG_ADDR_WIDTH, `__REG_ADDR_WIDTH, width of si_addr.
- REG_DATA_WIDTH, `__REG_DATA_WIDTH, width of each register.
- NUM_REGS, 4, number of registers (1..2^REG_ADDR_WIDTH-1).
- BASE_ADDR, 0, address of register 0; register i at BASE_ADDR+i.
- RESET_VALUES, 0, packed NUM_REGS*REG_DATA_WIDTH reset values; register i at bits [i*REG_DATA_WIDTH +: REG_DATA_WIDTH].
- SHADOW_MODE, 0, 0 = direct write, 1 = writes go to shadow, applied on commit.
- COMMIT_ADDR, {REG_ADDR_WIDTH{1'b1}}, commit address; decoded only when SHADOW_MODE=1. It must lie outside [BASE_ADDR, BASE_ADDR+NUM_REGS-1]; a violation triggers a simulation $error at elaboration.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- si_addr  in  REG_ADDR_WIDTH  bus address.
- si_data  in  REG_DATA_WIDTH  bus write data.
- si_rdy  in  1  master request; held high until si_ack seen.
- si_ack  out  1  registered one-cycle acknowledge.
- data  out  NUM_REGS*REG_DATA_WIDTH  packed active register values.
- data_upd  out  NUM_REGS  one-cycle pulse per register whose active value changed.
- shadow_dirty  out  1  shadow differs from committed state (SHADOW_MODE=1); tied 0 otherwise.

Behaviour:
- Hit condition:
  - si_addr in [BASE_ADDR, BASE_ADDR+NUM_REGS-1], or
  - si_addr==COMMIT_ADDR with SHADOW_MODE=1.
- FSM IDLE / ACK / HOLD:
  - IDLE: on si_rdy=1 and hit, perform the access at this edge and go to ACK. A miss or si_rdy=0 stays in IDLE, with no ack and no write; the address belongs to another slave.
  - ACK: si_ack=1 for exactly this cycle. Next state is HOLD if si_rdy=1, else IDLE.
  - HOLD: si_ack=0, no accesses. Return to IDLE when si_rdy=0.
  - A held request is therefore acknowledged and written exactly once. A new transaction needs si_rdy low for at least one cycle.
- Latency:
  - data and data_upd update at the same edge that raises si_ack, one cycle after request sampling.
  - A back-to-back transaction is possible every 3 cycles minimum.
- Direct mode (SHADOW_MODE=0):
  - active[i] <= si_data.
  - data_upd[i]=1 during ACK only if the new value differs from the old.
- Shadow mode:
  - Register write: shadow[i] <= si_data and shadow_dirty <= 1; active and data are unchanged, and data_upd stays 0.
  - Commit write (si_data ignored): active <= shadow for all i, with data_upd[i]=1 for each i whose value changed, and shadow_dirty <= 0.
  - A commit with shadow_dirty=0 is still acknowledged, with no change and data_upd all 0.
- data_upd is 0 in all cycles except ACK.
- Reset (rst=0, asynchronous):
  - Active and shadow are set to RESET_VALUES; FSM to IDLE; si_ack=0, data_upd=0, shadow_dirty=0.
  - Reset mid-transaction aborts it without the write completing if asserted before the capture edge. After release, a still-high si_rdy with a hit is treated as a new request.
- No arithmetic beyond the address compare, which is done at REG_ADDR_WIDTH bits. BASE_ADDR+NUM_REGS must not exceed 2^REG_ADDR_WIDTH; no wrap-around is supported.

Test Plan:
Bench configuration: REG_ADDR_WIDTH=4, REG_DATA_WIDTH=16, NUM_REGS=4, BASE_ADDR=4'h8, RESET_VALUES={16'h4444,16'h3333,16'h2222,16'h1111}.
- Reset values: assert rst=0 mid-run, release -> data={4444,3333,2222,1111}; si_ack=0; data_upd=0; shadow_dirty=0.
- Direct write with held request: addr=4'hA, data=16'hBEEF, si_rdy held 5 cycles ->
  - si_ack high exactly one cycle, 1 cycle after request.
  - Register 2 = BEEF; data_upd=4'b0100 in that cycle; no second ack until si_rdy drops.
- Same-value write and miss: write 16'h1111 to addr 4'h8 -> ack, data_upd=0. Then addr 4'h3 with si_rdy=1 for 4 cycles -> no ack, data unchanged.
- Shadow mode (SHADOW_MODE=1, COMMIT_ADDR=4'hF): write 8<-0001, 9<-2222 ->
  - After the writes: data unchanged; shadow_dirty=1.
  - Commit -> data reg0=0001; data_upd=4'b0001 (reg1 unchanged); shadow_dirty=0.
  - Second commit -> ack, data_upd=0.
- Reset mid-transaction: raise si_rdy to addr 4'h9, data 16'h5A5A; assert rst=0 before the next posedge and release -> reg1 stays 2222; no ack during reset; a new ack and write follow after release if si_rdy is still high.
- Back-to-back: addr 8, 9, 10, 11 each with si_rdy pulsed, 1 idle cycle between -> four acks; each data_upd bit pulses in order; final data matches the writes.
